// File: rtl/retire_dbg_capture.sv
// retire_dbg_capture: captures the last write to a watched register, counts retires, tracks halt/trap, drives LED view
// Ports: i_clk/i_rst_n clock and async active-low reset; i_retire_* retire interface;
//        i_disp_sel async LED view select; o_dbg_result captured value; o_retire_count saturating count;
//        o_trap_pc PC of trapping instruction; o_state 00 RUN/01 HALTED/10 TRAPPED; o_led registered view.
module retire_dbg_capture #(
    parameter int WATCH_REG = 11,
    parameter int CNT_W     = 32,
    parameter int HB_BITS   = 25
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_retire_valid,
    input  logic [4:0]       i_retire_rd_waddr,
    input  logic [31:0]      i_retire_rd_wdata,
    input  logic             i_retire_trap,
    input  logic             i_retire_halt,
    input  logic [31:0]      i_retire_pc,
    input  logic [1:0]       i_disp_sel,
    output logic [31:0]      o_dbg_result,
    output logic [CNT_W-1:0] o_retire_count,
    output logic [31:0]      o_trap_pc,
    output logic [1:0]       o_state,
    output logic [9:0]       o_led
);
    typedef enum logic [1:0] {RUN = 2'b00, HALTED = 2'b01, TRAPPED = 2'b10} state_t;
    localparam logic [4:0] WATCH = 5'(WATCH_REG);
    state_t             r_state, w_state_nxt;
    logic               r_rel;
    logic [1:0]         r_sel_meta, r_sel_sync;
    logic [HB_BITS-1:0] r_hb;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_dbg, r_trap_pc;
    logic [9:0]         r_led, w_led_nxt;
    logic [CNT_W+9:0]   w_count_ext;
    logic               w_accept, w_capture;
    // r_rel stays low through the releasing edge so no retire is taken on it
    assign w_accept    = i_retire_valid && r_rel && (r_state == RUN);
    assign w_capture   = w_accept && (WATCH_REG != 0) && (i_retire_rd_waddr == WATCH) && !i_retire_trap;
    assign w_count_ext = {10'b0, r_count};
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)
            w_state_nxt = i_retire_trap ? TRAPPED : (i_retire_halt ? HALTED : RUN);
    end
    always_comb begin
        w_led_nxt = r_sel_sync == 2'b00 ? r_dbg[9:0] :
                    r_sel_sync == 2'b01 ? w_count_ext[9:0] :
                    r_sel_sync == 2'b10 ? r_trap_pc[11:2] :
                                          {r_state, r_hb[HB_BITS-1], 7'b0};
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rel      <= 1'b0;
            r_sel_meta <= 2'b0;
            r_sel_sync <= 2'b0;
            r_hb       <= '0;
            r_count    <= '0;
            r_dbg      <= '0;
            r_trap_pc  <= '0;
            r_led      <= '0;
        end else begin
            r_rel      <= 1'b1;
            r_sel_meta <= i_disp_sel;
            r_sel_sync <= r_sel_meta;
            r_hb       <= r_hb + HB_BITS'(1);
            r_led      <= w_led_nxt;
            if (w_accept && !(&r_count))
                r_count <= r_count + CNT_W'(1);
            if (w_capture)
                r_dbg <= i_retire_rd_wdata;
            if (w_accept && i_retire_trap)
                r_trap_pc <= i_retire_pc;
        end
    end
    assign o_dbg_result   = r_dbg;
    assign o_retire_count = r_count;
    assign o_trap_pc      = r_trap_pc;
    assign o_state        = r_state;
    assign o_led          = r_led;
endmodule

// File: tb/tb_retire_dbg_capture.sv
// tb_retire_dbg_capture: directed self-checking bench for retire_dbg_capture
module tb_retire_dbg_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        trap = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] pc = '0;
    logic [1:0]  sel = 2'b00;
    logic [31:0] dbg, tpc, dbg0, tpc0, cnt;
    logic [3:0]  cnt0;
    logic [1:0]  st, st0;
    logic [9:0]  led, led0;
    int          total = 0;
    int          bad = 0;
    int          toggles;
    logic        prev7;

    always #5 clk = ~clk;

    retire_dbg_capture #(.WATCH_REG(11), .CNT_W(32), .HB_BITS(4)) u_main (
        .i_clk(clk), .i_rst_n(rst_n), .i_retire_valid(valid), .i_retire_rd_waddr(waddr),
        .i_retire_rd_wdata(wdata), .i_retire_trap(trap), .i_retire_halt(halt), .i_retire_pc(pc),
        .i_disp_sel(sel), .o_dbg_result(dbg), .o_retire_count(cnt), .o_trap_pc(tpc),
        .o_state(st), .o_led(led));

    retire_dbg_capture #(.WATCH_REG(0), .CNT_W(4), .HB_BITS(25)) u_w0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_retire_valid(valid), .i_retire_rd_waddr(waddr),
        .i_retire_rd_wdata(wdata), .i_retire_trap(trap), .i_retire_halt(halt), .i_retire_pc(pc),
        .i_disp_sel(sel), .o_dbg_result(dbg0), .o_retire_count(cnt0), .o_trap_pc(tpc0),
        .o_state(st0), .o_led(led0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [4:0] a, input logic [31:0] d, input logic t, input logic h, input logic [31:0] p);
        valid = 1'b1; waddr = a; wdata = d; trap = t; halt = h; pc = p;
        tick();
        valid = 1'b0; trap = 1'b0; halt = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_dbg", dbg, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_tpc", tpc, 0);
        chk("rst_state", 32'(st), 0);
        chk("rst_led", 32'(led), 0);
        rst_n = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) retire(5'd11, 32'(i), 1'b0, 1'b0, 32'h100 + 32'(4 * i));
        chk("cap5_dbg", dbg, 5);
        chk("cap5_cnt", cnt, 5);
        chk("cap5_state", 32'(st), 0);
        chk("w0_dbg_a", dbg0, 0);
        tick();
        chk("cap5_led", 32'(led), 5);
        retire(5'd10, 32'hDEAD, 1'b0, 1'b0, 32'h200);
        chk("other_dbg", dbg, 5);
        chk("other_cnt", cnt, 6);
        for (int i = 0; i < 9; i++) retire(5'd12, 32'h0, 1'b0, 1'b0, 32'h204);
        chk("cnt15", cnt, 15);
        chk("w0_cnt15", 32'(cnt0), 15);
        for (int i = 0; i < 2; i++) retire(5'd11, 32'h55, 1'b0, 1'b0, 32'h208);
        chk("cnt17", cnt, 17);
        chk("w0_sat", 32'(cnt0), 15);
        chk("dbg55", dbg, 32'h55);
        chk("w0_dbg_b", dbg0, 0);
        retire(5'd11, 32'h3FF, 1'b0, 1'b1, 32'h20C);
        chk("halt_state", 32'(st), 1);
        chk("halt_dbg", dbg, 32'h3FF);
        chk("halt_cnt", cnt, 18);
        chk("w0_halt_cnt", 32'(cnt0), 15);
        for (int i = 0; i < 3; i++) retire(5'd11, 32'h1, 1'b0, 1'b0, 32'h210);
        chk("frz_cnt", cnt, 18);
        chk("frz_dbg", dbg, 32'h3FF);
        chk("frz_state", 32'(st), 1);
        chk("led_dbg3ff", 32'(led), 32'h3FF);
        sel = 2'b01;
        repeat (2) tick();
        chk("sel_lat2", 32'(led), 32'h3FF);
        tick();
        chk("sel_lat3", 32'(led), 18);
        sel = 2'b00;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", cnt, 0);
        chk("arst_state", 32'(st), 0);
        chk("arst_led", 32'(led), 0);
        #2 rst_n = 1'b1;
        tick();
        retire(5'd11, 32'h7, 1'b1, 1'b1, 32'h0000_0124);
        chk("trap_state", 32'(st), 2);
        chk("trap_pc", tpc, 32'h124);
        chk("trap_dbg", dbg, 0);
        chk("trap_cnt", cnt, 1);
        retire(5'd11, 32'h9, 1'b0, 1'b0, 32'h200);
        chk("trap_frz_cnt", cnt, 1);
        chk("trap_frz_pc", tpc, 32'h124);
        chk("trap_frz_dbg", dbg, 0);
        sel = 2'b10;
        repeat (2) tick();
        chk("pc_lat2", 32'(led), 0);
        tick();
        chk("pc_led", 32'(led), 32'h049);
        sel = 2'b00;
        valid = 1'b1; waddr = 5'd11; wdata = 32'h33;
        rst_n = 1'b0;
        #2;
        chk("mid_cnt", cnt, 0);
        chk("mid_state", 32'(st), 0);
        chk("mid_tpc", tpc, 0);
        chk("mid_led", 32'(led), 0);
        #1 rst_n = 1'b1;
        tick();
        chk("rel_edge_cnt", cnt, 0);
        chk("rel_edge_dbg", dbg, 0);
        tick();
        valid = 1'b0;
        chk("post_rel_cnt", cnt, 1);
        chk("post_rel_dbg", dbg, 32'h33);
        sel = 2'b11;
        repeat (3) tick();
        chk("hb_state_bits", 32'(led[9:8]), 0);
        chk("hb_low_bits", 32'(led[6:0]), 0);
        toggles = 0;
        prev7 = led[7];
        for (int i = 0; i < 16; i++) begin
            tick();
            if (led[7] !== prev7) toggles++;
            prev7 = led[7];
        end
        chk("hb_toggles", 32'(toggles), 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
